// File: rtl/wrr_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wrr_packet_arbiter
// Brief    : Weighted round-robin arbiter that holds grants for whole packets.
// Revision : 1.0 - initial release
// ============================================================================
module wrr_packet_arbiter #(
    parameter int N  = 4,
    parameter int WW = 4,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    i_req,
    input  logic [N-1:0]    i_last,
    input  logic [N*WW-1:0] i_weight,
    input  logic            i_ready,
    output logic [N-1:0]    o_grant,
    output logic            o_grant_valid,
    output logic [IW-1:0]   o_grant_idx
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [IW-1:0] C_PTR_RESET = IW'(N - 1);
    localparam logic [IW:0]   C_N_EXT     = (IW + 1)'(N);
    localparam logic [N-1:0]  C_ONE_HOT0  = N'(1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_grant;
    logic [N-1:0]   w_grant_nxt;
    logic           r_grant_valid;
    logic           w_valid_nxt;
    logic [IW-1:0]  r_grant_idx;
    logic [IW-1:0]  w_idx_nxt;
    logic [IW-1:0]  r_ptr;
    logic [IW-1:0]  w_ptr_nxt;
    logic [WW-1:0]  r_credit;
    logic [WW-1:0]  w_credit_nxt;

    logic           w_found;
    logic [IW-1:0]  w_sel;
    logic [IW:0]    w_cand;
    logic [WW-1:0]  w_sel_weight;
    logic [WW-1:0]  w_sel_credit;
    logic           w_cur_req;
    logic           w_cur_last;
    logic           w_beat;
    logic           w_arbitrate;

    // Rotating search: ptr+1 .. ptr+N, wrapped by subtraction.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = {1'b0, r_ptr} + (IW + 1)'(k);
            if (w_cand >= C_N_EXT) begin
                w_cand = w_cand - C_N_EXT;
            end
            if (!w_found && i_req[w_cand[IW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[IW-1:0];
            end
        end
    end

    always_comb begin
        w_sel_weight = '0;
        for (int i = 0; i < N; i++) begin
            if (w_sel == IW'(i)) begin
                w_sel_weight = i_weight[i*WW +: WW];
            end
        end
    end

    // A zero weight still earns one packet per turn.
    assign w_sel_credit = (w_sel_weight == '0) ? WW'(1) : w_sel_weight;

    assign w_cur_req  = i_req[r_grant_idx];
    assign w_cur_last = i_last[r_grant_idx];
    assign w_beat     = r_grant_valid & i_ready & w_cur_req;

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_valid_nxt  = r_grant_valid;
        w_idx_nxt    = r_grant_idx;
        w_ptr_nxt    = r_ptr;
        w_credit_nxt = r_credit;
        w_arbitrate  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_arbitrate = w_found;
            end
            ST_GRANT: begin
                if (!w_cur_req) begin
                    w_arbitrate = 1'b1;
                end else if (w_beat && w_cur_last) begin
                    if (r_credit > WW'(1)) begin
                        w_credit_nxt = r_credit - WW'(1);
                    end else begin
                        w_arbitrate = 1'b1;
                    end
                end
            end
        endcase

        // On release ptr already equals the released index, so it is searched last.
        if (w_arbitrate) begin
            if (w_found) begin
                w_state_nxt  = ST_GRANT;
                w_grant_nxt  = C_ONE_HOT0 << w_sel;
                w_valid_nxt  = 1'b1;
                w_idx_nxt    = w_sel;
                w_ptr_nxt    = w_sel;
                w_credit_nxt = w_sel_credit;
            end else begin
                w_state_nxt  = ST_IDLE;
                w_grant_nxt  = '0;
                w_valid_nxt  = 1'b0;
                w_idx_nxt    = '0;
                w_credit_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_ptr         <= C_PTR_RESET;
            r_credit      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= w_valid_nxt;
            r_grant_idx   <= w_idx_nxt;
            r_ptr         <= w_ptr_nxt;
            r_credit      <= w_credit_nxt;
        end
    end

    assign o_grant       = r_grant;
    assign o_grant_valid = r_grant_valid;
    assign o_grant_idx   = r_grant_idx;

endmodule
`default_nettype wire

// File: tb/tb_wrr_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wrr_packet_arbiter
// Brief    : Scoreboard bench for wrr_packet_arbiter with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wrr_packet_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    last = '0;
    logic [N*WW-1:0] weight = '0;
    logic            ready = 1'b0;
    logic [N-1:0]    grant;
    logic            grant_valid;
    logic [IW-1:0]   grant_idx;

    always #5 clk = ~clk;

    wrr_packet_arbiter #(.N(N), .WW(WW)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req         (req),
        .i_last        (last),
        .i_weight      (weight),
        .i_ready       (ready),
        .o_grant       (grant),
        .o_grant_valid (grant_valid),
        .o_grant_idx   (grant_idx)
    );

    typedef struct {
        logic [N-1:0]  g;
        logic          v;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model state: who holds the grant, how many packets remain, where the search starts.
    bit   m_valid  = 1'b0;
    int   m_idx    = 0;
    int   m_ptr    = N - 1;
    int   m_credit = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int eff_weight(input logic [N*WW-1:0] w, input int i);
        int v;
        v = int'(w[i*WW +: WW]);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_step();
        bit   rel;
        bit   found;
        int   c;
        exp_t e;
        rel = 1'b0;
        if (reset) begin
            m_valid = 1'b0; m_idx = 0; m_ptr = N - 1; m_credit = 0;
        end else begin
            if (!m_valid)                  rel = (req != '0);
            else if (!req[m_idx])          rel = 1'b1;
            else if (ready && last[m_idx]) begin
                if (m_credit > 1) m_credit = m_credit - 1;
                else              rel = 1'b1;
            end
            if (rel) begin
                m_valid = 1'b0; m_idx = 0; m_credit = 0;
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    c = (m_ptr + k) % N;
                    if (!found && req[c]) begin
                        found = 1'b1; m_valid = 1'b1; m_idx = c; m_ptr = c;
                        m_credit = eff_weight(weight, c);
                    end
                end
            end
        end
        e.g   = m_valid ? N'(1 << m_idx) : '0;
        e.v   = m_valid;
        e.idx = IW'(m_idx);
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [N-1:0] rq, input logic [N-1:0] ls,
                         input logic [N*WW-1:0] wt, input logic rd, input logic rs);
        @(negedge clk);
        req = rq; last = ls; weight = wt; ready = rd; reset = rs;
        model_step();
        if (rs) begin
            #1;
            chk("reset_grant", 32'(grant), 32'h0);
            chk("reset_valid", 32'(grant_valid), 32'h0);
            chk("reset_idx", 32'(grant_idx), 32'h0);
        end
    endtask

    task automatic after_edge(input string name, input logic [N-1:0] exp_g);
        @(posedge clk);
        #2;
        chk(name, 32'(grant), 32'(exp_g));
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_grant", 32'(grant), 32'(mon_e.g));
            chk("sb_valid", 32'(grant_valid), 32'(mon_e.v));
            chk("sb_idx", 32'(grant_idx), 32'(mon_e.idx));
        end
    end

    initial begin
        logic [N-1:0]    seq1 [5];
        logic [N-1:0]    r_rq;
        logic [N*WW-1:0] r_wt;
        int              beats;
        seq1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Full rotation, weight 1 everywhere.
        drive('0, '0, '0, 1'b0, 1'b1);
        drive('0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 4'b1111, 16'h1111, 1'b1, 1'b0);
            after_edge("rotate_seq", seq1[i]);
        end

        // Weight 3 vs weight 1.
        drive('0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            drive(4'b0101, 4'b1111, 16'h0103, 1'b1, 1'b0);
            after_edge("weighted_seq", (i % 4 == 3) ? 4'b0100 : 4'b0001);
        end

        // Single requester, ready toggling, 4-beat packets back to back.
        drive('0, '0, '0, 1'b0, 1'b1);
        beats = 0;
        for (int i = 0; i < 14; i++) begin
            ready = (i % 2 == 1);
            drive(4'b0010, (beats == 3) ? 4'b0010 : 4'b0000, 16'h1111, ready, 1'b0);
            if (m_valid && ready) beats = (beats == 3) ? 0 : beats + 1;
            after_edge("hold_no_bubble", 4'b0010);
        end

        // Granted requester abandons mid-packet; successor gets its own weight.
        drive('0, '0, '0, 1'b0, 1'b1);
        drive(4'b0100, 4'b0000, 16'h2500, 1'b1, 1'b0);
        after_edge("abandon_pre", 4'b0100);
        drive(4'b1000, 4'b0000, 16'h2500, 1'b1, 1'b0);
        after_edge("abandon_switch", 4'b1000);
        drive(4'b1010, 4'b1000, 16'h2500, 1'b1, 1'b0);
        after_edge("reload_credit", 4'b1000);
        drive(4'b1010, 4'b1000, 16'h2500, 1'b1, 1'b0);
        after_edge("reload_expire", 4'b0010);

        // Zero weight behaves as one.
        drive('0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(4'b0011, 4'b0011, 16'h0010, 1'b1, 1'b0);
            after_edge("zero_weight", (i % 2 == 0) ? 4'b0001 : 4'b0010);
        end

        // Reset mid-packet, then ptr is back at N-1.
        drive(4'b0100, 4'b0000, 16'h0500, 1'b1, 1'b0);
        drive(4'b0100, 4'b0000, 16'h0500, 1'b1, 1'b0);
        after_edge("pre_reset", 4'b0100);
        drive(4'b0100, 4'b0000, 16'h0500, 1'b1, 1'b1);
        drive(4'b0110, 4'b0000, 16'h0500, 1'b1, 1'b0);
        after_edge("post_reset_first", 4'b0010);

        // Randomised traffic.
        r_rq = '0;
        r_wt = 16'h3121;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) r_rq = N'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) r_wt = 16'($urandom);
            drive(r_rq, N'($urandom_range(0, 15)), r_wt,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 149) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
